// File: rtl/fix_order_if.sv
// Field stream from the FIX parser into the decoder, and the order record handshake out of it.
interface fix_order_if #(
    parameter int unsigned TAG_WIDTH   = 24,
    parameter int unsigned VALUE_WIDTH = 168,
    parameter int unsigned SYM_BYTES   = 8
);
    logic [TAG_WIDTH-1:0]   tag;
    logic                   tag_valid;
    logic [VALUE_WIDTH-1:0] value;
    logic                   value_valid;
    logic                   parser_valid;
    logic                   parser_not_valid;
    logic                   order_valid;
    logic                   order_ready;
    logic                   order_side;
    logic [31:0]            order_qty;
    logic [31:0]            order_price;
    logic [8*SYM_BYTES-1:0] order_symbol;
    logic                   order_reject;
    logic                   order_overflow;

    modport master (
        output tag, tag_valid, value, value_valid, parser_valid, parser_not_valid, order_ready,
        input  order_valid, order_side, order_qty, order_price, order_symbol, order_reject,
               order_overflow
    );

    modport slave (
        input  tag, tag_valid, value, value_valid, parser_valid, parser_not_valid, order_ready,
        output order_valid, order_side, order_qty, order_price, order_symbol, order_reject,
               order_overflow
    );
endinterface

// File: rtl/fix_order_decoder.sv
// FIX New Order Single decoder: captures tagged fields, validates them, and converts ASCII
// qty/price to binary while the next message is already being captured.
module fix_order_decoder #(
    parameter int unsigned TAG_WIDTH   = 24,
    parameter int unsigned VALUE_WIDTH = 168,
    parameter int unsigned NUM_DIGITS  = 10,
    parameter int unsigned PX_FRAC     = 2,
    parameter int unsigned SYM_BYTES   = 8
) (
    input logic        clk,
    input logic        rst,
    fix_order_if.slave bus
);
    localparam int unsigned DW = 8 * NUM_DIGITS;
    localparam int unsigned SW = 8 * SYM_BYTES;

    localparam logic [TAG_WIDTH-1:0] TagType = TAG_WIDTH'(16'h3335);
    localparam logic [TAG_WIDTH-1:0] TagQty  = TAG_WIDTH'(16'h3338);
    localparam logic [TAG_WIDTH-1:0] TagPx   = TAG_WIDTH'(16'h3434);
    localparam logic [TAG_WIDTH-1:0] TagSide = TAG_WIDTH'(16'h3534);
    localparam logic [TAG_WIDTH-1:0] TagSym  = TAG_WIDTH'(16'h3535);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StQty   = 3'd1;
    localparam logic [2:0] StPx    = 3'd2;
    localparam logic [2:0] StScale = 3'd3;
    localparam logic [2:0] StOut   = 3'd4;

    function automatic logic [31:0] mul10(input logic [31:0] a);
        return (a << 3) + (a << 1);
    endfunction

    logic [TAG_WIDTH-1:0] tag_q;
    logic                 tag_seen_q;
    logic [4:0]           mask_q;  // {55, 54, 44, 38, 35}
    logic                 type_ok_q, side_ok_q, side_q, qty_hi_q, px_hi_q;
    logic [DW-1:0]        qty_q, px_q;
    logic [SW-1:0]        sym_q;
    logic                 msg_end, hi_nz, msg_ok;

    assign msg_end = bus.parser_valid | bus.parser_not_valid;
    assign hi_nz   = (bus.value >> DW) != '0;
    assign msg_ok  = (&mask_q) & type_ok_q & side_ok_q & ~qty_hi_q & ~px_hi_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q      <= '0;
            tag_seen_q <= 1'b0;
            mask_q     <= '0;
            type_ok_q  <= 1'b0;
            side_ok_q  <= 1'b0;
            side_q     <= 1'b0;
            qty_hi_q   <= 1'b0;
            px_hi_q    <= 1'b0;
            qty_q      <= '0;
            px_q       <= '0;
            sym_q      <= '0;
        end else if (msg_end) begin
            tag_q      <= '0;
            tag_seen_q <= 1'b0;
            mask_q     <= '0;
        end else begin
            if (bus.tag_valid) begin
                tag_q      <= bus.tag;
                tag_seen_q <= 1'b1;
            end
            if (bus.value_valid && tag_seen_q) begin
                case (tag_q)
                    TagType: begin
                        mask_q[0] <= 1'b1;
                        type_ok_q <= bus.value == VALUE_WIDTH'(8'h44);
                    end
                    TagQty: begin
                        mask_q[1] <= 1'b1;
                        qty_q     <= bus.value[DW-1:0];
                        qty_hi_q  <= hi_nz;
                    end
                    TagPx: begin
                        mask_q[2] <= 1'b1;
                        px_q      <= bus.value[DW-1:0];
                        px_hi_q   <= hi_nz;
                    end
                    TagSide: begin
                        mask_q[3] <= 1'b1;
                        side_ok_q <= (bus.value == VALUE_WIDTH'(8'h31)) ||
                                     (bus.value == VALUE_WIDTH'(8'h32));
                        side_q    <= bus.value[1];
                    end
                    TagSym: begin
                        mask_q[4] <= 1'b1;
                        sym_q     <= bus.value[SW-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [2:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d, frac_q, frac_d;
    logic          dot_q, dot_d, err_q, err_d;
    logic [DW-1:0] qs_q, qs_d, ps_q, ps_d;
    logic [31:0]   acc_qty_q, acc_qty_d, acc_px_q, acc_px_d;
    logic          side_w_q, side_w_d;
    logic [SW-1:0] sym_w_q, sym_w_d;
    logic          reject_q, reject_d, overflow_q, overflow_d;
    logic [7:0]    ch;
    logic          is_dig, done;
    logic [31:0]   dig;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frac_d     = frac_q;
        dot_d      = dot_q;
        err_d      = err_q;
        qs_d       = qs_q;
        ps_d       = ps_q;
        acc_qty_d  = acc_qty_q;
        acc_px_d   = acc_px_q;
        side_w_d   = side_w_q;
        sym_w_d    = sym_w_q;
        reject_d   = 1'b0;
        overflow_d = bus.parser_valid && (state_q != StIdle);
        done       = 1'b0;
        ch         = (state_q == StQty) ? qs_q[DW-1 -: 8] : ps_q[DW-1 -: 8];
        is_dig     = (ch >= 8'h30) && (ch <= 8'h39);
        dig        = {24'd0, ch - 8'h30};

        case (state_q)
            StIdle: begin
                if (bus.parser_valid) begin
                    if (msg_ok) begin
                        state_d   = StQty;
                        cnt_d     = 8'(NUM_DIGITS - 1);
                        frac_d    = '0;
                        dot_d     = 1'b0;
                        err_d     = 1'b0;
                        qs_d      = qty_q;
                        ps_d      = px_q;
                        acc_qty_d = '0;
                        acc_px_d  = '0;
                        side_w_d  = side_q;
                        sym_w_d   = sym_q;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StQty: begin
                qs_d = qs_q << 8;
                if (is_dig) acc_qty_d = mul10(acc_qty_q) + dig;
                else if (ch != 8'h00) err_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StPx;
                    cnt_d   = 8'(NUM_DIGITS - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StPx: begin
                ps_d = ps_q << 8;
                if (is_dig) begin
                    // Fraction digits past PX_FRAC are truncated, not rounded.
                    if (!dot_q || (frac_q < 8'(PX_FRAC))) begin
                        acc_px_d = mul10(acc_px_q) + dig;
                        frac_d   = frac_q + {7'd0, dot_q};
                    end
                end else if ((ch == 8'h2E) && !dot_q) begin
                    dot_d = 1'b1;
                end else if (ch != 8'h00) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    if (PX_FRAC == 0) begin
                        done = 1'b1;
                    end else begin
                        state_d = StScale;
                        cnt_d   = 8'(PX_FRAC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StScale: begin
                if (frac_q < 8'(PX_FRAC)) begin
                    acc_px_d = mul10(acc_px_q);
                    frac_d   = frac_q + 8'd1;
                end
                if (cnt_q == '0) done = 1'b1;
                else cnt_d = cnt_q - 8'd1;
            end
            StOut: begin
                if (bus.order_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            if (err_d) begin
                reject_d = 1'b1;
                state_d  = StIdle;
            end else begin
                state_d = StOut;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            frac_q     <= '0;
            dot_q      <= 1'b0;
            err_q      <= 1'b0;
            qs_q       <= '0;
            ps_q       <= '0;
            acc_qty_q  <= '0;
            acc_px_q   <= '0;
            side_w_q   <= 1'b0;
            sym_w_q    <= '0;
            reject_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frac_q     <= frac_d;
            dot_q      <= dot_d;
            err_q      <= err_d;
            qs_q       <= qs_d;
            ps_q       <= ps_d;
            acc_qty_q  <= acc_qty_d;
            acc_px_q   <= acc_px_d;
            side_w_q   <= side_w_d;
            sym_w_q    <= sym_w_d;
            reject_q   <= reject_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.order_valid    = state_q == StOut;
    assign bus.order_side     = side_w_q;
    assign bus.order_qty      = acc_qty_q;
    assign bus.order_price    = acc_px_q;
    assign bus.order_symbol   = sym_w_q;
    assign bus.order_reject   = reject_q;
    assign bus.order_overflow = overflow_q;
endmodule
